stream_rr_arbiter: RTL and testbench

- Shares one byte-wide output stream between NUM_REQ requester streams using a packet-locked round-robin policy.
- Each requester has a valid/ready/last stream. Once a packet is granted, its requester owns the output until the beat marked last has been accepted.
- Sits in front of the stream sink in the sample design; its registered output drives the sink's stream_in_valid/stream_in_data.

---
 rtl/stream_arb_pkg.sv | 35 +++
 rtl/stream_rr_arbiter_if.sv | 29 ++
 rtl/stream_rr_arbiter_picker.sv | 21 ++
 rtl/stream_rr_arbiter.sv | 118 +++++++++++
 tb/tb_stream_rr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the packet-locked round-robin stream arbiter.
// Holds the arbiter state encoding, default widths and the rotate-priority pick.
package stream_arb_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_t;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_CNT_WIDTH  = 16;
   localparam int MAX_REQ        = 8;
   localparam int MAX_IDX_W      = 3;

   // Returns {found, idx}: first set bit of req scanning ptr, ptr+1, ... mod n.
   function automatic logic [MAX_IDX_W:0] rr_pick(
      input logic [MAX_REQ-1:0]   req,
      input logic [MAX_IDX_W-1:0] ptr,
      input int                   n
   );
      logic [MAX_IDX_W:0]   res;
      logic [MAX_IDX_W+1:0] k;
      res = '0;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         if (i < n) begin
            k = {2'b00, ptr} + 5'(i);
            if (k >= 5'(n)) k = k - 5'(n);
            if (req[k[MAX_IDX_W-1:0]]) res = {1'b1, k[MAX_IDX_W-1:0]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Requester-side and output-side stream handshakes of the arbiter.
// slave: the arbiter; master: the requesters plus the downstream sink.
interface stream_rr_arbiter_if
   import stream_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          stream_out_valid;
   logic [DATA_WIDTH-1:0]         stream_out_data;
   logic                          stream_out_last;
   logic                          stream_out_ready;

   modport slave (
      input  req_valid, req_data, req_last, stream_out_ready,
      output req_ready, stream_out_valid, stream_out_data, stream_out_last
   );

   modport master (
      output req_valid, req_data, req_last, stream_out_ready,
      input  req_ready, stream_out_valid, stream_out_data, stream_out_last
   );

endinterface

// File: rtl/stream_rr_arbiter_picker.sv
// Combinational rotate-and-priority-encode: first requester at or after ptr.
// Reusable wherever a round-robin choice is needed.
module rr_priority_picker
   import stream_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               found_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [MAX_IDX_W:0] pick;

   assign pick    = rr_pick(MAX_REQ'(req_i), MAX_IDX_W'(ptr_i), NUM_REQ);
   assign found_o = pick[MAX_IDX_W];
   assign idx_o   = IDX_W'(pick[MAX_IDX_W-1:0]);

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one registered output stream.
// A granted requester owns the output until its last beat is accepted.
module stream_rr_arbiter
   import stream_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   stream_rr_arbiter_if.slave   bus,
   output logic [IDX_W-1:0]     grant_idx,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] pkt_count
);

   arb_state_t            state_q, state_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]      grant_q, grant_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic                  pick_found;
   logic [IDX_W-1:0]      pick_idx;
   logic                  slot_free;
   logic                  xfer;
   logic                  beat_last;
   logic [DATA_WIDTH-1:0] beat_data;
   logic [NUM_REQ-1:0]    ready_vec;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i   (bus.req_valid),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_comb begin
      slot_free   = !out_valid_q || bus.stream_out_ready;
      beat_data   = bus.req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
      beat_last   = bus.req_last[grant_q];
      ready_vec   = '0;
      xfer        = 1'b0;
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;

      unique case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               state_d = ARB_LOCKED;
               grant_d = pick_idx;
            end
         end
         ARB_LOCKED: begin
            ready_vec[grant_q] = slot_free;
            xfer = bus.req_valid[grant_q] && slot_free;
            if (xfer && beat_last) begin
               state_d  = ARB_IDLE;
               rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1))
                          ? '0 : grant_q + 1'b1;
            end
         end
         default: ;
      endcase

      // A load wins over a drain so accept+load keeps valid high.
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = beat_data;
         out_last_d  = beat_last;
      end else if (bus.stream_out_ready) begin
         out_valid_d = 1'b0;
      end

      cnt_d = cnt_q + CNT_WIDTH'(out_valid_q && bus.stream_out_ready
                                 && out_last_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ARB_IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.req_ready        = ready_vec;
   assign bus.stream_out_valid = out_valid_q;
   assign bus.stream_out_data  = out_data_q;
   assign bus.stream_out_last  = out_last_q;
   assign grant_idx            = grant_q;
   assign busy                 = (state_q == ARB_LOCKED);
   assign pkt_count            = cnt_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized bench for stream_rr_arbiter: packet-level reference model
// feeding a scoreboard queue that a monitor drains on output accepts.
module tb_stream_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int CW = 4;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   stream_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

   logic [IW-1:0] grant_idx;
   logic          busy;
   logic [CW-1:0] pkt_count;

   stream_rr_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus.slave),
      .grant_idx (grant_idx),
      .busy      (busy),
      .pkt_count (pkt_count)
   );

   int errors = 0;
   int checks = 0;

   // Stimulus controls
   logic [N-1:0] en_mask = '0;
   int  vprob = 100;
   int  rprob = 100;
   int  maxlen = 4;
   bit  fixed_data = 0;
   bit  gen_on = 0;
   bit  chk_rst = 0;
   bit  final_chk = 0;
   bit  drain_timeout = 0;

   // Requester packet generators
   bit        act [N];
   int        plen[N];
   int        bidx[N];
   logic [7:0] base[N];
   bit        acc [N];

   // Reference model
   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } beat_t;
   beat_t sb[$];
   int         owner;
   int         ptr;
   int         m_grant;
   bit         m_ov;
   bit         m_olast;
   logic [CW-1:0] m_cnt;
   bit         stall_prev;
   logic [7:0] prev_data;
   logic       prev_last;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, got, exp, $time);
      end
   endtask

   function automatic int rr_first(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   initial begin
      owner = -1; ptr = 0; m_grant = 0; m_ov = 0; m_olast = 0;
      m_cnt = '0; stall_prev = 0; prev_data = '0; prev_last = 0;
   end

   // Model + monitor process: all comparisons happen here.
   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      bit           idle_now;
      bit           xfer;
      beat_t        e;
      beat_t        got;
      if (!reset_n) begin
         if (chk_rst) begin
            chk("rst_out_valid", 32'(bus.stream_out_valid), 0);
            chk("rst_out_data",  32'(bus.stream_out_data), 0);
            chk("rst_out_last",  32'(bus.stream_out_last), 0);
            chk("rst_busy",      32'(busy), 0);
            chk("rst_grant",     32'(grant_idx), 0);
            chk("rst_pkt_count", 32'(pkt_count), 0);
            chk("rst_req_ready", 32'(bus.req_ready), 0);
         end
         owner = -1; ptr = 0; m_grant = 0; m_ov = 0; m_olast = 0;
         m_cnt = '0; stall_prev = 0;
         sb.delete();
      end else begin
         // monitor: scoreboard pop on accepted output beat
         if (bus.stream_out_valid && stall_prev) begin
            chk("stall_data", 32'(bus.stream_out_data), 32'(prev_data));
            chk("stall_last", 32'(bus.stream_out_last), 32'(prev_last));
         end
         if (bus.stream_out_valid && bus.stream_out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_beat", 32'(bus.stream_out_data), 32'hFFFF);
            end else begin
               e = sb.pop_front();
               got = {bus.stream_out_last, bus.stream_out_data};
               chk("out_beat", 32'(got), 32'(e));
            end
         end
         stall_prev = bus.stream_out_valid && !bus.stream_out_ready;
         prev_data  = bus.stream_out_data;
         prev_last  = bus.stream_out_last;

         // model: expected controls for this cycle
         exp_rdy = '0;
         if (owner >= 0 && (!m_ov || bus.stream_out_ready))
            exp_rdy[owner] = 1'b1;
         chk("req_ready",  32'(bus.req_ready), 32'(exp_rdy));
         chk("busy",       32'(busy), 32'(owner >= 0));
         chk("grant_idx",  32'(grant_idx), 32'(m_grant));
         chk("out_valid",  32'(bus.stream_out_valid), 32'(m_ov));
         chk("pkt_count",  32'(pkt_count), 32'(m_cnt));

         // model: advance across the coming edge
         idle_now = (owner < 0);
         if (m_ov && bus.stream_out_ready && m_olast) m_cnt = m_cnt + 1'b1;
         xfer = !idle_now && bus.req_valid[owner] && exp_rdy[owner];
         if (xfer) begin
            sb.push_back({bus.req_last[owner],
                          bus.req_data[owner*DW +: DW]});
            m_ov = 1;
            m_olast = bus.req_last[owner];
            if (bus.req_last[owner]) begin
               ptr = (owner + 1) % N;
               owner = -1;
            end
         end else if (bus.stream_out_ready) begin
            m_ov = 0;
         end
         if (idle_now && |bus.req_valid) begin
            owner = rr_first(bus.req_valid, ptr);
            m_grant = owner;
         end
      end
      if (final_chk) begin
         chk("drain_timeout", 32'(drain_timeout), 0);
         chk("sb_empty", 32'(sb.size()), 0);
      end
   end

   // Requester and sink driver
   initial begin
      logic [N-1:0]    v, l;
      logic [N*DW-1:0] d;
      for (int i = 0; i < N; i++) begin
         act[i] = 0; plen[i] = 0; bidx[i] = 0; base[i] = '0; acc[i] = 0;
      end
      bus.req_valid = '0;
      bus.req_last  = '0;
      bus.req_data  = '0;
      bus.stream_out_ready = 1'b0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++)
            acc[i] = bus.req_valid[i] && bus.req_ready[i];
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (!reset_n) begin
               act[i] = 0;
            end else if (acc[i]) begin
               bidx[i]++;
               if (bidx[i] == plen[i]) act[i] = 0;
            end
            if (!act[i] && gen_on && en_mask[i] && reset_n &&
                $urandom_range(99) < vprob) begin
               act[i]  = 1;
               bidx[i] = 0;
               plen[i] = 1 + $urandom_range(maxlen - 1);
               base[i] = fixed_data ? 8'(8'hA0 + i) : 8'($urandom);
            end
            v[i] = act[i] && ($urandom_range(99) < vprob);
            d[i*DW +: DW] = act[i] ? 8'(base[i] + bidx[i]) : 8'($urandom);
            l[i] = act[i] ? (bidx[i] == plen[i] - 1) : 1'($urandom);
         end
         bus.req_valid = v;
         bus.req_data  = d;
         bus.req_last  = l;
         bus.stream_out_ready = ($urandom_range(99) < rprob);
      end
   end

   task automatic pulse_reset();
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      chk_rst = 1;
      @(negedge clk);
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      chk_rst = 0;
   endtask

   initial begin
      int  cyc;
      bit  any_act;
      #2;
      reset_n = 1'b0;
      chk_rst = 1;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      chk_rst = 0;

      // lone requester 2, multi-beat packets
      en_mask = 4'b0100; vprob = 100; rprob = 100; maxlen = 3;
      gen_on = 1;
      repeat (40) @(posedge clk);

      // everyone valid, single-beat packets, rotating order
      en_mask = 4'b1111; maxlen = 1; fixed_data = 1;
      repeat (40) @(posedge clk);

      // long packets with output stalls of five cycles
      fixed_data = 0; maxlen = 4;
      for (int r = 0; r < 6; r++) begin
         repeat (7) @(posedge clk);
         rprob = 0;
         repeat (5) @(posedge clk);
         rprob = 100;
      end

      // random traffic with mid-packet valid gaps and reset pulses
      vprob = 60; rprob = 50; maxlen = 5;
      for (int r = 0; r < 4; r++) begin
         repeat (400) @(posedge clk);
         pulse_reset();
      end
      repeat (500) @(posedge clk);

      // drain outstanding packets
      gen_on = 0; vprob = 100; rprob = 100;
      cyc = 0;
      do begin
         @(posedge clk);
         cyc++;
         any_act = 0;
         for (int i = 0; i < N; i++) any_act |= act[i];
      end while ((any_act || busy || bus.stream_out_valid) && cyc < 2000);
      drain_timeout = (cyc >= 2000);
      repeat (2) @(posedge clk);
      #1;
      final_chk = 1;
      @(negedge clk);
      #1;
      final_chk = 0;
      @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
